// File: rtl/ysyx_23060096_mcycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: FSM state encoding,
// RV32I opcodes, ImmGen ext_op codes and PC source selects.
package ysyx_23060096_defs;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_WAIT_INST = 4'd2,
        S_DECODE    = 4'd3,
        S_EXEC      = 4'd4,
        S_MEM_REQ   = 4'd5,
        S_MEM_WAIT  = 4'd6,
        S_WB        = 4'd7,
        S_HALT      = 4'd8,
        S_TRAP      = 4'd9
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h00100073;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [1:0] PCSEL_PC4     = 2'b00;
    localparam logic [1:0] PCSEL_PC_IMM  = 2'b01;
    localparam logic [1:0] PCSEL_RS1_IMM = 2'b10;

endpackage

// File: rtl/ysyx_23060096_mcycle_ctrl_if.sv
// IFU and LSU bus ports of the control sequencer, grouped with master
// (sequencer) and slave (fabric) views.
interface ysyx_23060096_mcycle_ctrl_if;

    // A request transfers on a rising edge where valid and ready are both 1;
    // valid, once raised, holds until that edge. A response (rsp_valid) is only
    // accepted in the cycle after the request transfer or later, never with it.
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_inst;
    logic        lsu_req_valid;
    logic        lsu_req_wen;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;

    modport master (
        output ifu_req_valid,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_inst,
        output lsu_req_valid,
        output lsu_req_wen,
        input  lsu_req_ready,
        input  lsu_rsp_valid
    );

    modport slave (
        input  ifu_req_valid,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_inst,
        input  lsu_req_valid,
        input  lsu_req_wen,
        output lsu_req_ready,
        output lsu_rsp_valid
    );

endinterface

// File: rtl/ysyx_23060096_opdec.sv
// Combinational opcode decoder: immediate select, instruction class flags,
// EBREAK detection and illegal-instruction detection.
module ysyx_23060096_opdec
    import ysyx_23060096_defs::*;
(
    input  logic [31:0] ir_i,
    output logic [2:0]  ext_op_o,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        is_branch_o,
    output logic        is_jal_o,
    output logic        is_jalr_o,
    output logic        writes_rd_o,
    output logic        is_ebreak_o,
    output logic        illegal_o
);

    logic legal;

    always_comb begin
        ext_op_o    = EXT_I;
        is_load_o   = 1'b0;
        is_store_o  = 1'b0;
        is_branch_o = 1'b0;
        is_jal_o    = 1'b0;
        is_jalr_o   = 1'b0;
        legal       = 1'b1;
        case (ir_i[6:0])
            OPC_LOAD:            is_load_o = 1'b1;
            OPC_OP_IMM, OPC_OP:  ext_op_o  = EXT_I;
            OPC_JALR:            is_jalr_o = 1'b1;
            OPC_LUI, OPC_AUIPC:  ext_op_o  = EXT_U;
            OPC_STORE: begin
                ext_op_o   = EXT_S;
                is_store_o = 1'b1;
            end
            OPC_BRANCH: begin
                ext_op_o    = EXT_B;
                is_branch_o = 1'b1;
            end
            OPC_JAL: begin
                ext_op_o = EXT_J;
                is_jal_o = 1'b1;
            end
            // EBREAK is the only SYSTEM word this core handles.
            OPC_SYSTEM:          legal = (ir_i == INST_EBREAK);
            default:             legal = 1'b0;
        endcase
    end

    assign is_ebreak_o = (ir_i == INST_EBREAK);
    assign illegal_o   = ~legal;
    assign writes_rd_o = ~(is_store_o | is_branch_o);

endmodule

// File: rtl/ysyx_23060096_mcycle_ctrl.sv
// Multi-cycle control sequencer: fetches one instruction at a time, holds it in
// the IR and steps PC update, regfile write and load/store through a Moore FSM.
module ysyx_23060096_mcycle_ctrl
    import ysyx_23060096_defs::*;
(
    input  logic                               clk,
    input  logic                               rstn,
    ysyx_23060096_mcycle_ctrl_if.master        bus,
    output logic [31:0]                        ir,
    output logic [2:0]                         ext_op,
    input  logic                               branch_taken,
    output logic                               rf_we,
    output logic                               pc_we,
    output logic [1:0]                         pc_sel,
    output logic                               instret,
    output logic                               halt,
    output logic                               trap,
    output state_e                             dbg_state_o
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [2:0]  ext_op_q, ext_op_d;
    logic        bt_q, bt_d;

    logic [2:0]  dec_ext_op;
    logic        is_load, is_store, is_branch, is_jal, is_jalr;
    logic        writes_rd, is_ebreak, illegal;

    ysyx_23060096_opdec u_opdec (
        .ir_i        (ir_q),
        .ext_op_o    (dec_ext_op),
        .is_load_o   (is_load),
        .is_store_o  (is_store),
        .is_branch_o (is_branch),
        .is_jal_o    (is_jal),
        .is_jalr_o   (is_jalr),
        .writes_rd_o (writes_rd),
        .is_ebreak_o (is_ebreak),
        .illegal_o   (illegal)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            ir_q     <= 32'd0;
            ext_op_q <= EXT_I;
            bt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ext_op_q <= ext_op_d;
            bt_q     <= bt_d;
        end
    end

    // Inputs steer only the next state; every strobe depends on state and
    // registered IR/branch flag alone.
    always_comb begin
        state_d           = state_q;
        ir_d              = ir_q;
        ext_op_d          = ext_op_q;
        bt_d              = bt_q;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_wen   = 1'b0;
        rf_we             = 1'b0;
        pc_we             = 1'b0;
        pc_sel            = PCSEL_PC4;
        instret           = 1'b0;
        halt              = 1'b0;
        trap              = 1'b0;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH: begin
                bus.ifu_req_valid = 1'b1;
                if (bus.ifu_req_ready) state_d = S_WAIT_INST;
            end
            S_WAIT_INST: begin
                if (bus.ifu_rsp_valid) begin
                    ir_d    = bus.ifu_rsp_inst;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ext_op_d = dec_ext_op;
                if (is_ebreak)    state_d = S_HALT;
                else if (illegal) state_d = S_TRAP;
                else              state_d = S_EXEC;
            end
            S_EXEC: begin
                bt_d    = branch_taken;
                state_d = (is_load || is_store) ? S_MEM_REQ : S_WB;
            end
            S_MEM_REQ: begin
                bus.lsu_req_valid = 1'b1;
                bus.lsu_req_wen   = is_store;
                if (bus.lsu_req_ready) state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (bus.lsu_rsp_valid) state_d = S_WB;
            end
            S_WB: begin
                pc_we   = 1'b1;
                instret = 1'b1;
                rf_we   = writes_rd;
                if (is_jalr)                           pc_sel = PCSEL_RS1_IMM;
                else if (is_jal || (is_branch && bt_q)) pc_sel = PCSEL_PC_IMM;
                state_d = S_FETCH;
            end
            S_HALT:      halt = 1'b1;
            S_TRAP:      trap = 1'b1;
            default:     state_d = S_IDLE;
        endcase
    end

    assign ir          = ir_q;
    assign ext_op      = ext_op_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_23060096_mcycle_ctrl.sv
// Directed bench for the control sequencer with a reactive IFU/LSU fabric and a
// write-back scoreboard of {ir, rf_we, pc_sel, ext_op}.
module tb_ysyx_23060096_mcycle_ctrl;
    import ysyx_23060096_defs::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] ir;
    logic [2:0]  ext_op;
    logic        branch_taken;
    logic        rf_we, pc_we, instret, halt, trap;
    logic [1:0]  pc_sel;
    state_e      dbg_state;

    ysyx_23060096_mcycle_ctrl_if bus ();

    ysyx_23060096_mcycle_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus),
        .ir           (ir),
        .ext_op       (ext_op),
        .branch_taken (branch_taken),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .instret      (instret),
        .halt         (halt),
        .trap         (trap),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_BEQ   = 32'h00000463;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_JALR  = 32'h00008067;
    localparam logic [31:0] I_LUI   = 32'h000010B7;
    localparam logic [31:0] I_EBRK  = 32'h00100073;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

    int chk_cnt = 0;
    int err_cnt = 0;
    logic [37:0] exp_q[$];

    logic        ifu_pend, lsu_pend, bt_val;
    logic [31:0] cur_inst;
    int          lsu_cnt, lsu_dly, cycles;
    int          rf_cnt, pc_cnt, ret_cnt, lv_cnt, wen_bad, fetch_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_out();
        return {19'd0, bus.ifu_req_valid, bus.lsu_req_valid, bus.lsu_req_wen, rf_we, pc_we,
                pc_sel, instret, halt, trap, ir, ext_op};
    endfunction

    // Fabric reacts to what it saw this cycle; values take effect at the next edge.
    task automatic fabric_drive();
        bus.ifu_rsp_valid = ifu_pend;
        bus.ifu_rsp_inst  = ifu_pend ? cur_inst : $urandom();
        ifu_pend          = bus.ifu_req_valid;
        bus.ifu_req_ready = bus.ifu_req_valid;
        if (bus.lsu_req_valid) lsu_cnt++;
        bus.lsu_rsp_valid = lsu_pend;
        bus.lsu_req_ready = bus.lsu_req_valid && (lsu_cnt > lsu_dly);
        lsu_pend          = bus.lsu_req_ready;
        branch_taken      = (cycles == 4) ? bt_val : ~bt_val;
    endtask

    task automatic reset_release(input string tag);
        rstn              = 1'b0;
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_inst  = 32'd0;
        bus.lsu_req_ready = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
        branch_taken      = 1'b0;
        ifu_pend          = 1'b0;
        lsu_pend          = 1'b0;
        tick();
        tick();
        check({tag, " outputs"}, all_out(), 64'd0);
        rstn = 1'b1;
    endtask

    // Starts one cycle before FETCH; returns on the WB sample.
    task automatic run_inst(input string tag, input logic [31:0] inst, input logic bt,
                            input int dly, input logic [37:0] exp_rec, input int exp_cycles,
                            input int exp_lv, input logic exp_wen);
        logic        done;
        logic [37:0] got;
        exp_q.push_back(exp_rec);
        cur_inst = inst; bt_val = bt; lsu_dly = dly; lsu_cnt = 0;
        cycles = 0; rf_cnt = 0; pc_cnt = 0; ret_cnt = 0; lv_cnt = 0; wen_bad = 0; fetch_cnt = 0;
        done = 1'b0;
        while (!done && cycles < 40) begin
            tick();
            cycles++;
            if (rf_we) rf_cnt++;
            if (pc_we) pc_cnt++;
            if (instret) ret_cnt++;
            if (bus.ifu_req_valid) fetch_cnt++;
            if (bus.lsu_req_valid) begin
                lv_cnt++;
                if (bus.lsu_req_wen !== exp_wen) wen_bad++;
            end
            if (pc_we) begin
                done = 1'b1;
                got  = exp_q.pop_front();
                check({tag, " wb"}, {26'd0, ir, rf_we, pc_sel, ext_op}, {26'd0, got});
            end
            fabric_drive();
        end
        check({tag, " done"}, 64'(done), 64'd1);
        if (!done) exp_q.delete();
        check({tag, " cycles"}, 64'(cycles), 64'(exp_cycles));
        check({tag, " rf_we pulses"}, 64'(rf_cnt), 64'(exp_rec[5]));
        check({tag, " pc_we/instret"}, {32'(pc_cnt), 32'(ret_cnt)}, {32'd1, 32'd1});
        check({tag, " lsu_valid cycles"}, 64'(lv_cnt), 64'(exp_lv));
        check({tag, " lsu_wen/fetch"}, {32'(wen_bad), 32'(fetch_cnt)}, {32'd0, 32'd1});
    endtask

    task automatic run_term(input string tag, input logic [31:0] inst,
                            input logic exp_halt, input logic exp_trap);
        int quiet;
        cur_inst = inst; bt_val = 1'b0; lsu_dly = 0; lsu_cnt = 0; cycles = 0;
        while (cycles < 20) begin
            tick();
            cycles++;
            if (halt || trap) break;
            fabric_drive();
        end
        check({tag, " cycles"}, 64'(cycles), 64'd4);
        check({tag, " flags"}, {62'd0, halt, trap}, {62'd0, exp_halt, exp_trap});
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            fabric_drive();
            tick();
            if (bus.ifu_req_valid || bus.lsu_req_valid || rf_we || pc_we || instret) quiet++;
        end
        check({tag, " quiet"}, 64'(quiet), 64'd0);
        check({tag, " sticky"}, {62'd0, halt, trap}, {62'd0, exp_halt, exp_trap});
    endtask

    initial begin
        logic reached;
        int   d;
        rstn = 1'b0;
        cycles = 0;
        bt_val = 1'b0;
        cur_inst = 32'd0;
        lsu_dly = 0;
        lsu_cnt = 0;
        reset_release("reset");

        run_inst("addi", I_ADDI, 1'b0, 0, {I_ADDI, 1'b1, PCSEL_PC4, EXT_I}, 5, 0, 1'b0);
        run_inst("lw dly2", I_LW, 1'b0, 2, {I_LW, 1'b1, PCSEL_PC4, EXT_I}, 9, 3, 1'b0);
        run_inst("sw", I_SW, 1'b0, 0, {I_SW, 1'b0, PCSEL_PC4, EXT_S}, 7, 1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(0, 3);
            if (i[0]) run_inst("rand sw", I_SW, 1'b1, d, {I_SW, 1'b0, PCSEL_PC4, EXT_S}, 7 + d, d + 1, 1'b1);
            else      run_inst("rand lw", I_LW, 1'b1, d, {I_LW, 1'b1, PCSEL_PC4, EXT_I}, 7 + d, d + 1, 1'b0);
        end
        run_inst("beq taken", I_BEQ, 1'b1, 0, {I_BEQ, 1'b0, PCSEL_PC_IMM, EXT_B}, 5, 0, 1'b0);
        run_inst("beq not", I_BEQ, 1'b0, 0, {I_BEQ, 1'b0, PCSEL_PC4, EXT_B}, 5, 0, 1'b0);
        run_inst("jal", I_JAL, 1'b0, 0, {I_JAL, 1'b1, PCSEL_PC_IMM, EXT_J}, 5, 0, 1'b0);
        run_inst("jalr", I_JALR, 1'b1, 0, {I_JALR, 1'b1, PCSEL_RS1_IMM, EXT_I}, 5, 0, 1'b0);
        run_inst("lui", I_LUI, 1'b0, 0, {I_LUI, 1'b1, PCSEL_PC4, EXT_U}, 5, 0, 1'b0);

        run_term("ebreak", I_EBRK, 1'b1, 1'b0);
        reset_release("halt clear");
        run_term("illegal", I_BAD, 1'b0, 1'b1);
        reset_release("trap clear");
        run_term("ecall", I_ECALL, 1'b0, 1'b1);
        reset_release("ecall clear");

        // Reset while MEM_WAIT, with a load response arriving under reset.
        cur_inst = I_LW; lsu_dly = 0; lsu_cnt = 0; cycles = 0; reached = 1'b0;
        while (!reached && cycles < 30) begin
            tick();
            cycles++;
            fabric_drive();
            if (lsu_pend) reached = 1'b1;
        end
        check("rst memwait reach", 64'(reached), 64'd1);
        tick();
        rstn = 1'b0;
        bus.lsu_rsp_valid = 1'b1;
        bus.ifu_req_ready = 1'b0;
        bus.lsu_req_ready = 1'b0;
        tick();
        check("rst memwait out", all_out(), 64'd0);
        tick();
        check("rst memwait hold", all_out(), 64'd0);
        rstn = 1'b1;
        bus.lsu_rsp_valid = 1'b0;
        ifu_pend = 1'b0;
        lsu_pend = 1'b0;
        tick();
        check("rst memwait resume", {62'd0, bus.ifu_req_valid, bus.lsu_req_valid}, {62'd0, 1'b1, 1'b0});

        // Reset while FETCH, then a normal instruction afterwards.
        rstn = 1'b0;
        tick();
        check("rst fetch out", all_out(), 64'd0);
        rstn = 1'b1;
        run_inst("addi after rst", I_ADDI, 1'b0, 0, {I_ADDI, 1'b1, PCSEL_PC4, EXT_I}, 5, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ysyx_23060096_mcycle_ctrl.md
# ysyx_23060096_mcycle_ctrl

Multi-cycle control sequencer for the NPC core. It fetches one instruction at a time over a valid/ready instruction port and holds it in an internal instruction register. It decodes the opcode into the `ExtOP` select for the immediate generator and sequences PC update, register-file write and load/store handshakes through a Moore FSM. It sits between the IFU/LSU bus ports and the ImmGen/ALU/regfile datapath; one instruction is in flight at any time.

## Interface
No parameters.
- `clk` in 1: single clock, all state updates on rising edge
- `rstn` in 1: synchronous, active-low reset
- `ifu_req_valid` out 1: fetch request for the current PC
- `ifu_req_ready` in 1: IFU accepts the request
- `ifu_rsp_valid` in 1: instruction word valid
- `ifu_rsp_inst` in 32: fetched instruction
- `ir` out 32: instruction register; `ir[31:7]` drives ImmGen `inst`
- `ext_op` out 3: immediate select; 000 I, 001 U, 010 S, 011 B, 100 J
- `branch_taken` in 1: ALU compare result, sampled in EXEC
- `lsu_req_valid` out 1: memory request
- `lsu_req_wen` out 1: 1 store, 0 load
- `lsu_req_ready` in 1: LSU accepts the request
- `lsu_rsp_valid` in 1: load data returned or store completed
- `rf_we` out 1: register-file write strobe
- `pc_we` out 1: PC update strobe
- `pc_sel` out 2: 00 pc+4, 01 pc+imm (JAL, taken branch), 10 rs1+imm (JALR)
- `instret` out 1: one-cycle pulse per retired instruction
- `halt` out 1: sticky, set by EBREAK
- `trap` out 1: sticky, set by an illegal opcode

## Operation
- States: IDLE, FETCH, WAIT_INST, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, TRAP.
- IDLE: next state is FETCH unconditionally.
- FETCH: `ifu_req_valid`=1 and held until `ifu_req_ready`=1 is sampled, then WAIT_INST.
- WAIT_INST: on `ifu_rsp_valid`=1, `ir` ← `ifu_rsp_inst` and go to DECODE. `ifu_rsp_valid` is ignored in every other state.
- DECODE: `ext_op` is registered from `ir[6:0]`.
  - LOAD (0000011), OP-IMM (0010011), JALR (1100111), OP (0110011) → 000.
  - LUI (0110111), AUIPC (0010111) → 001.
  - STORE (0100011) → 010.
  - BRANCH (1100011) → 011.
  - JAL (1101111) → 100.
- DECODE next state:
  - `ir` == 32'h00100073 → HALT.
  - Any other SYSTEM word, or an unlisted opcode → TRAP.
  - Otherwise → EXEC.
- EXEC: `branch_taken` is registered. LOAD/STORE go to MEM_REQ; all others go to WB.
- MEM_REQ: `lsu_req_valid`=1 and `lsu_req_wen` = (opcode == STORE), both held until `lsu_req_ready`=1, then MEM_WAIT.
- MEM_WAIT: on `lsu_rsp_valid`=1 go to WB.
- WB:
  - `pc_we`=1 and `instret`=1.
  - `rf_we`=1 for every class except STORE and BRANCH; the regfile discards writes to x0.
  - `pc_sel`: 01 for JAL or a BRANCH with registered `branch_taken`=1; 10 for JALR; else 00.
  - Next state FETCH.
- HALT/TRAP: terminal states, left only by reset. `halt`/`trap` is 1; all strobes and request valids are 0.

## Timing
- While `rstn`=0 at a clock edge: state ← IDLE, `ir` ← 0, `ext_op` ← 000, registered `branch_taken` ← 0. All outputs are 0 the cycle after.
- Reset mid-operation in any state behaves the same. Outstanding IFU/LSU responses are dropped, and valids deassert the cycle after the reset edge.
- All outputs except `ir` and `ext_op` are decoded from state only; there are no combinational input→output paths.
- Latency with ready/valid returned in the cycle following each request:
  - Non-memory instruction: FETCH, WAIT_INST, DECODE, EXEC, WB = 5 cycles.
  - Load/store: 7 cycles.
  - Each extra wait cycle on ready or rsp adds 1 cycle.
- Responses in the same cycle as a request: `ifu_rsp_valid` asserted in the same cycle as the `ifu_req_ready` handshake is not accepted. The fabric guarantees a response at least 1 cycle after the handshake. The same rule applies to the LSU.
- `ext_op` is stable from the cycle after DECODE through WB.

## Structure
- Shared package (`ysyx_23060096_defs`) holds:
  - state encodings (4-bit);
  - opcode constants;
  - `ext_op` codes (shared with ImmGen);
  - `pc_sel` codes.
- Sub-module `ysyx_23060096_opdec` (combinational): decodes `ir` into `ext_op`, class flags (is_load, is_store, is_branch, is_jal, is_jalr, writes_rd), `is_ebreak` and `illegal`. The FSM uses these flags for its DECODE transitions and WB strobes.

## Test plan
- `addi x1,x0,5` (0x00500093), immediate handshakes → `ext_op`=000; exactly one `rf_we`/`pc_we`/`instret` pulse, in cycle 5; `pc_sel`=00; `lsu_req_valid` never asserts.
- `lw x2,0(x1)` (0x0000A103), `lsu_req_ready` delayed 2 cycles → `lsu_req_valid` held high for 3 cycles with `lsu_req_wen`=0; `rf_we` in WB; total 9 cycles.
- `beq x0,x0,8` (0x00000463):
  - `branch_taken`=1 → `ext_op`=011, `pc_sel`=01, `rf_we`=0.
  - Repeat with `branch_taken`=0 → `pc_sel`=00.
- `jal x1,16` (0x010000EF) → `ext_op`=100, `pc_sel`=01, `rf_we`=1; then `jalr` (0x00008067) → `ext_op`=000, `pc_sel`=10.
- 0x00100073 → `halt`=1 from the cycle after DECODE; no further `ifu_req_valid`. 0xFFFFFFFF → `trap`=1 sticky; both clear only after `rstn`=0.
- Reset asserted in MEM_WAIT and in FETCH → all outputs 0 the next cycle; `lsu_rsp_valid` arriving during reset is ignored; fetch resumes 2 cycles after `rstn` returns high (IDLE, then FETCH).
